// File: rtl/spi_regif_slave.sv
// SPI slave register interface: 8-bit header (W flag + address) followed by DATA_W data bits.
// All SPI pins are oversampled in the Clk domain; reads fetch data via RdAddr/RdReq and writes pulse WrEn.
module spi_regif_slave #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              SPI_CLK,
  input  logic              SPI_CS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              RdReq,
  input  logic [DATA_W-1:0] DataToRPi,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [DATA_W-1:0] WrData,
  output logic              Busy,
  output logic              FrameErr
);

  localparam int         FRAME_LEN  = 8 + DATA_W;
  localparam logic [6:0] HDR_LAST   = 7'd7;
  localparam logic [6:0] FRAME_LAST = 7'(FRAME_LEN - 1);
  localparam logic       SCK_IDLE   = (CPOL != 0);
  localparam bit         SAMPLE_ON_TRAIL = (CPHA != 0);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

  state_t state, next_state;

  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  // NOTE: CS synchronisers reset low so that releasing reset while CS is held
  // low mid-frame produces no fall event; decoding resumes at the next real frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sck_q  <= {3{SCK_IDLE}};
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], SPI_CLK};
      cs_q   <= {cs_q[1:0], SPI_CS};
      mosi_q <= {mosi_q[0], SPI_MOSI};
    end
  end

  logic sck_edge, lead_evt, trail_evt, sample_evt, shift_evt;
  logic cs_fall, cs_rise, mosi_s;

  assign sck_edge   = sck_q[2] ^ sck_q[1];
  assign lead_evt   = sck_edge && (sck_q[2] == SCK_IDLE);
  assign trail_evt  = sck_edge && (sck_q[1] == SCK_IDLE);
  assign sample_evt = SAMPLE_ON_TRAIL ? trail_evt : lead_evt;
  assign shift_evt  = SAMPLE_ON_TRAIL ? lead_evt : trail_evt;
  assign cs_fall    = cs_q[2] & ~cs_q[1];
  assign cs_rise    = ~cs_q[2] & cs_q[1];
  assign mosi_s     = mosi_q[1];

  logic [6:0]        bit_cnt;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] shift_in;
  logic              is_wr;
  logic [ADDR_W-1:0] wr_addr_hold;
  logic [ADDR_W-1:0] hdr_addr;
  logic              header_done, last_sample, frame_err;

  assign shift_in    = {sreg[DATA_W-2:0], mosi_s};
  assign hdr_addr    = ADDR_W'({sreg[6:0], mosi_s});
  assign header_done = (state == HEADER) && sample_evt && (bit_cnt == HDR_LAST);
  assign last_sample = (state == DATA) && sample_evt && (bit_cnt == FRAME_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    frame_err  = 1'b0;
    unique case (state)
      IDLE:   if (cs_fall) next_state = HEADER;
      HEADER: begin
        if (cs_rise) begin
          next_state = IDLE;
          frame_err  = 1'b1;
        end else if (header_done) begin
          next_state = DATA;
        end
      end
      DATA: begin
        // A CS rise coinciding with the final sample still completes the frame.
        if (last_sample) begin
          next_state = cs_rise ? IDLE : DONE;
        end else if (cs_rise) begin
          next_state = IDLE;
          frame_err  = 1'b1;
        end
      end
      DONE:    if (cs_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      SPI_MISO     <= 1'b0;
      RdAddr       <= '0;
      RdReq        <= 1'b0;
      WrEn         <= 1'b0;
      WrAddr       <= '0;
      WrData       <= '0;
      Busy         <= 1'b0;
      FrameErr     <= 1'b0;
      bit_cnt      <= '0;
      sreg         <= '0;
      is_wr        <= 1'b0;
      wr_addr_hold <= '0;
    end else begin
      RdReq    <= 1'b0;
      WrEn     <= 1'b0;
      FrameErr <= frame_err;
      Busy     <= (next_state != IDLE);

      if (next_state != DATA)
        SPI_MISO <= 1'b0;
      else if (state == DATA && !is_wr && shift_evt)
        SPI_MISO <= sreg[DATA_W-1];

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            bit_cnt <= '0;
            sreg    <= '0;
          end
        end
        HEADER: begin
          if (sample_evt) begin
            sreg    <= shift_in;
            bit_cnt <= bit_cnt + 7'd1;
            if (bit_cnt == HDR_LAST) begin
              is_wr <= sreg[6];
              if (sreg[6]) begin
                wr_addr_hold <= hdr_addr;
              end else begin
                RdAddr <= hdr_addr;
                RdReq  <= 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (is_wr) begin
            if (sample_evt) begin
              sreg    <= shift_in;
              bit_cnt <= bit_cnt + 7'd1;
            end
            if (last_sample) begin
              WrEn   <= 1'b1;
              WrAddr <= wr_addr_hold;
              WrData <= shift_in;
            end
          end else begin
            // Read data arrives the cycle after RdReq, ahead of the first data shift.
            if (RdReq)
              sreg <= DataToRPi;
            else if (shift_evt)
              sreg <= {sreg[DATA_W-2:0], 1'b0};
            if (sample_evt)
              bit_cnt <= bit_cnt + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regif_slave.sv
// Bench for spi_regif_slave: three instances (mode 0, mode 3, mode 1 with 4/16-bit widths)
// driven one at a time by a behavioural SPI master and checked against a register model.
module tb_spi_regif_slave;

  localparam int HALF = 6;

  logic Clk = 1'b0;
  logic rst_n;
  logic cs_drv, sck_drv, mosi;
  int   sel;

  int cfg_cpol [3] = '{0, 1, 0};
  int cfg_cpha [3] = '{0, 1, 1};
  int cfg_aw   [3] = '{7, 7, 4};
  int cfg_dw   [3] = '{32, 32, 16};

  always #5 Clk = ~Clk;

  logic cs0, cs1, cs2, sck0, sck1, sck2;
  assign cs0  = (sel == 0) ? cs_drv : 1'b1;
  assign cs1  = (sel == 1) ? cs_drv : 1'b1;
  assign cs2  = (sel == 2) ? cs_drv : 1'b1;
  assign sck0 = (sel == 0) ? sck_drv : 1'b0;
  assign sck1 = (sel == 1) ? sck_drv : 1'b1;
  assign sck2 = (sel == 2) ? sck_drv : 1'b0;

  logic        miso0, miso1, miso2, rr0, rr1, rr2, we0, we1, we2;
  logic        busy0, busy1, busy2, fe0, fe1, fe2;
  logic [6:0]  ra0, ra1, wa0, wa1;
  logic [3:0]  ra2, wa2;
  logic [31:0] wd0, wd1, dt0, dt1;
  logic [15:0] wd2, dt2;

  logic [63:0] mem [3][128];
  assign dt0 = mem[0][ra0][31:0];
  assign dt1 = mem[1][ra1][31:0];
  assign dt2 = mem[2][{3'b0, ra2}][15:0];

  spi_regif_slave #(.ADDR_W(7), .DATA_W(32), .CPOL(0), .CPHA(0)) u_m0 (
    .Clk(Clk), .Reset_n(rst_n), .SPI_CLK(sck0), .SPI_CS(cs0), .SPI_MOSI(mosi),
    .SPI_MISO(miso0), .RdAddr(ra0), .RdReq(rr0), .DataToRPi(dt0), .WrEn(we0),
    .WrAddr(wa0), .WrData(wd0), .Busy(busy0), .FrameErr(fe0));
  spi_regif_slave #(.ADDR_W(7), .DATA_W(32), .CPOL(1), .CPHA(1)) u_m3 (
    .Clk(Clk), .Reset_n(rst_n), .SPI_CLK(sck1), .SPI_CS(cs1), .SPI_MOSI(mosi),
    .SPI_MISO(miso1), .RdAddr(ra1), .RdReq(rr1), .DataToRPi(dt1), .WrEn(we1),
    .WrAddr(wa1), .WrData(wd1), .Busy(busy1), .FrameErr(fe1));
  spi_regif_slave #(.ADDR_W(4), .DATA_W(16), .CPOL(0), .CPHA(1)) u_m1 (
    .Clk(Clk), .Reset_n(rst_n), .SPI_CLK(sck2), .SPI_CS(cs2), .SPI_MOSI(mosi),
    .SPI_MISO(miso2), .RdAddr(ra2), .RdReq(rr2), .DataToRPi(dt2), .WrEn(we2),
    .WrAddr(wa2), .WrData(wd2), .Busy(busy2), .FrameErr(fe2));

  // Loopback user logic: writes land in mem, reads are served combinationally.
  always @(negedge Clk) begin
    if (we0) mem[0][wa0] = {32'b0, wd0};
    if (we1) mem[1][wa1] = {32'b0, wd1};
    if (we2) mem[2][{3'b0, wa2}] = {48'b0, wd2};
  end

  logic        miso, rd_req, wr_en, busy, frame_err;
  logic [6:0]  rd_addr, wr_addr;
  logic [63:0] wr_data;
  always_comb begin
    case (sel)
      1: begin
        miso = miso1; rd_req = rr1; wr_en = we1; busy = busy1; frame_err = fe1;
        rd_addr = ra1; wr_addr = wa1; wr_data = {32'b0, wd1};
      end
      2: begin
        miso = miso2; rd_req = rr2; wr_en = we2; busy = busy2; frame_err = fe2;
        rd_addr = {3'b0, ra2}; wr_addr = {3'b0, wa2}; wr_data = {48'b0, wd2};
      end
      default: begin
        miso = miso0; rd_req = rr0; wr_en = we0; busy = busy0; frame_err = fe0;
        rd_addr = ra0; wr_addr = wa0; wr_data = {32'b0, wd0};
      end
    endcase
  end

  int          n_rdreq = 0, n_wren = 0, n_ferr = 0;
  logic [6:0]  last_rd_addr, last_wr_addr;
  logic [63:0] last_wr_data;
  always @(negedge Clk) begin
    if (rst_n) begin
      if (rd_req) begin n_rdreq++; last_rd_addr = rd_addr; end
      if (wr_en) begin n_wren++; last_wr_addr = wr_addr; last_wr_data = wr_data; end
      if (frame_err) n_ferr++;
    end
  end

  int n_cmp = 0, n_bad = 0;
  logic [63:0] model [3][128];

  function automatic logic [63:0] dmask(input int dw);
    return (dw >= 64) ? '1 : ((64'(1) << dw) - 64'(1));
  endfunction

  function automatic logic [63:0] field(input logic [127:0] rx, input int shift, input int width);
    logic [127:0] t;
    t = (rx >> shift) & ((128'(1) << width) - 128'(1));
    return t[63:0];
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Master: sends hdr then data MSB first, captures MISO on the master sample edge.
  task automatic run_frame(input logic [7:0] hdr, input logic [63:0] data, input int nbits,
                           output logic [127:0] rx);
    int   cpol, cpha, dw;
    logic b;
    cpol = cfg_cpol[sel]; cpha = cfg_cpha[sel]; dw = cfg_dw[sel];
    rx = '0;
    sck_drv = 1'(cpol);
    cs_drv  = 1'b0;
    repeat (HALF) @(negedge Clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < 8)            b = hdr[7-i];
      else if (i < 8 + dw)  b = data[dw-1-(i-8)];
      else                  b = 1'($urandom_range(0, 1));
      if (cpha == 0) begin
        mosi = b;
        repeat (HALF) @(negedge Clk);
        rx = {rx[126:0], miso};
        sck_drv = ~1'(cpol);
        repeat (HALF) @(negedge Clk);
        sck_drv = 1'(cpol);
      end else begin
        sck_drv = ~1'(cpol);
        mosi = b;
        repeat (HALF) @(negedge Clk);
        rx = {rx[126:0], miso};
        sck_drv = 1'(cpol);
        repeat (HALF) @(negedge Clk);
      end
    end
    repeat (HALF) @(negedge Clk);
  endtask

  // Raise CS, return the number of Clk until Busy drops (bounded).
  task automatic finish_frame(output int lat);
    cs_drv = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (!busy) begin lat = n; break; end
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_timeout: got busy=1 expected busy=0 within 20 Clk");
    end
    repeat (6) @(negedge Clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    cmp({tag, "_ctl"}, 64'({miso, rd_req, wr_en, busy, frame_err}), 64'd0);
    cmp({tag, "_addr"}, 64'({rd_addr, wr_addr}), 64'd0);
    cmp({tag, "_wdata"}, wr_data, 64'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge Clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_idle_outputs($sformatf("reset_s%0d", s));
    end
    sel = 0;
    rst_n = 1'b1;
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_read_mode0();
    logic [127:0] rx;
    int r0, w0, f0, lat;
    sel = 0;
    mem[0][5] = 64'hDEADBEEF; model[0][5] = 64'hDEADBEEF;
    r0 = n_rdreq; w0 = n_wren; f0 = n_ferr;
    run_frame(8'h05, '0, 40, rx);
    finish_frame(lat);
    cmp("rd0_rdreq_cnt", 64'(n_rdreq - r0), 64'd1);
    cmp("rd0_rdaddr", 64'(last_rd_addr), 64'd5);
    cmp("rd0_miso_hdr", field(rx, 32, 8), 64'h00);
    cmp("rd0_miso_data", field(rx, 0, 32), 64'hDEADBEEF);
    cmp("rd0_no_wren", 64'(n_wren - w0), 64'd0);
    cmp("rd0_no_ferr", 64'(n_ferr - f0), 64'd0);
  endtask

  task automatic test_write_mode3();
    logic [127:0] rx;
    int w0, f0, lat;
    sel = 1;
    w0 = n_wren; f0 = n_ferr;
    run_frame(8'h83, 64'h12345678, 40, rx);
    finish_frame(lat);
    model[1][3] = 64'h12345678;
    cmp("wr3_wren_cnt", 64'(n_wren - w0), 64'd1);
    cmp("wr3_wraddr", 64'(last_wr_addr), 64'd3);
    cmp("wr3_wrdata", last_wr_data, 64'h12345678);
    cmp("wr3_no_ferr", 64'(n_ferr - f0), 64'd0);
    cmp("wr3_busy_drop_in_3_4", 64'(lat >= 3 && lat <= 4), 64'd1);
  endtask

  task automatic test_abort();
    logic [127:0] rx;
    logic [63:0]  d;
    int w0, f0, lat;
    sel = 1;
    w0 = n_wren; f0 = n_ferr;
    run_frame(8'h81, 64'hCAFEF00D, 20, rx);
    finish_frame(lat);
    cmp("abort_no_wren", 64'(n_wren - w0), 64'd0);
    cmp("abort_ferr_once", 64'(n_ferr - f0), 64'd1);
    d = 64'($urandom);
    w0 = n_wren; f0 = n_ferr;
    run_frame(8'h81, d, 40, rx);
    finish_frame(lat);
    model[1][1] = d;
    cmp("abort_next_wren", 64'(n_wren - w0), 64'd1);
    cmp("abort_next_wrdata", last_wr_data, d);
    cmp("abort_next_no_ferr", 64'(n_ferr - f0), 64'd0);
  endtask

  task automatic test_overlength();
    logic [127:0] rx;
    logic [63:0]  d;
    int r0, f0, lat;
    sel = 0;
    d = 64'($urandom);
    mem[0][7'h12] = d; model[0][7'h12] = d;
    r0 = n_rdreq; f0 = n_ferr;
    run_frame(8'h12, '0, 48, rx);
    finish_frame(lat);
    cmp("ovl_rdreq_once", 64'(n_rdreq - r0), 64'd1);
    cmp("ovl_data", field(rx, 8, 32), d);
    cmp("ovl_tail_zero", field(rx, 0, 8), 64'd0);
    cmp("ovl_no_ferr", 64'(n_ferr - f0), 64'd0);
  endtask

  task automatic test_reset_midframe();
    logic [127:0] rx;
    logic [63:0]  d;
    int w0, f0, lat;
    sel = 0;
    w0 = n_wren; f0 = n_ferr;
    run_frame(8'h8A, 64'h0BADC0DE, 30, rx);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rstmid");
    cs_drv = 1'b1;
    repeat (4) @(negedge Clk);
    rst_n = 1'b1;
    repeat (8) @(negedge Clk);
    cmp("rstmid_no_wren", 64'(n_wren - w0), 64'd0);
    cmp("rstmid_no_ferr", 64'(n_ferr - f0), 64'd0);
    d = 64'($urandom);
    run_frame(8'h8A, d, 40, rx);
    finish_frame(lat);
    model[0][7'h0A] = d;
    cmp("rstmid_next_wren", 64'(n_wren - w0), 64'd1);
    cmp("rstmid_next_wraddr", 64'(last_wr_addr), 64'h0A);
    cmp("rstmid_next_wrdata", last_wr_data, d);
  endtask

  task automatic test_param_sweep();
    logic [127:0] rx;
    int lat;
    sel = 2;
    run_frame(8'h8F, 64'hA5C3, 24, rx);
    finish_frame(lat);
    model[2][15] = 64'hA5C3;
    cmp("sweep_wraddr", 64'(last_wr_addr), 64'hF);
    cmp("sweep_wrdata", last_wr_data, 64'hA5C3);
    run_frame(8'h0F, '0, 24, rx);
    finish_frame(lat);
    cmp("sweep_readback", field(rx, 0, 16), 64'hA5C3);
    cmp("sweep_hdr_miso", field(rx, 16, 8), 64'h00);
  endtask

  task automatic test_random();
    logic [127:0] rx;
    logic [63:0]  d;
    logic [7:0]   hdr;
    int aw, dw, addr, hi, lat, r0, w0;
    bit wr;
    for (int s = 0; s < 3; s++) begin
      sel = s; aw = cfg_aw[s]; dw = cfg_dw[s];
      for (int k = 0; k < 8; k++) begin
        wr   = 1'($urandom_range(0, 1));
        addr = $urandom_range(0, (1 << aw) - 1);
        hi   = $urandom_range(0, 127);
        hdr  = {wr, 7'((hi & ~((1 << aw) - 1)) | addr)};
        d    = {32'($urandom), 32'($urandom)} & dmask(dw);
        r0 = n_rdreq; w0 = n_wren;
        run_frame(hdr, d, 8 + dw, rx);
        finish_frame(lat);
        if (wr) begin
          model[s][addr] = d;
          cmp($sformatf("rnd_s%0d_k%0d_wren", s, k), 64'(n_wren - w0), 64'd1);
          cmp($sformatf("rnd_s%0d_k%0d_wraddr", s, k), 64'(last_wr_addr), 64'(addr));
          cmp($sformatf("rnd_s%0d_k%0d_wrdata", s, k), last_wr_data, d);
        end else begin
          cmp($sformatf("rnd_s%0d_k%0d_rdreq", s, k), 64'(n_rdreq - r0), 64'd1);
          cmp($sformatf("rnd_s%0d_k%0d_rdaddr", s, k), 64'(last_rd_addr), 64'(addr));
          cmp($sformatf("rnd_s%0d_k%0d_rddata", s, k), field(rx, 0, dw), model[s][addr]);
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 128; a++) begin
        mem[s][a] = '0;
        model[s][a] = '0;
      end
    sel = 0; cs_drv = 1'b1; sck_drv = 1'b0; mosi = 1'b0; rst_n = 1'b1;
    #2;
    test_reset();
    test_read_mode0();
    test_write_mode3();
    test_abort();
    test_overlength();
    test_reset_midframe();
    test_param_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
